// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite RAM responder with byte-strobe writes and SLVERR outside the mapped window.
// Read data is valid two cycles after AR; a write commits on the last of AW/W and B follows. A stalled R or B freezes only its own channel.
module axi_lite_ram_slave #(
   parameter int          MEM_WORDS_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] axi_araddr,
   input  logic        axi_arvalid,
   output logic        axi_arready,
   input  logic [2:0]  axi_arprot,
   output logic [31:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rvalid,
   input  logic        axi_rready,
   input  logic [31:0] axi_awaddr,
   input  logic        axi_awvalid,
   output logic        axi_awready,
   input  logic [2:0]  axi_awprot,
   input  logic [31:0] axi_wdata,
   input  logic [3:0]  axi_wstrb,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   output logic [1:0]  axi_bresp,
   output logic        axi_bvalid,
   input  logic        axi_bready
);

   localparam int          MEM_WORDS = 2 ** MEM_WORDS_LOG2;
   localparam logic [0:0]  W_IDLE    = 1'b0;
   localparam logic [0:0]  W_RESP    = 1'b1;
   localparam logic [1:0]  R_IDLE    = 2'd0;
   localparam logic [1:0]  R_READ    = 2'd1;
   localparam logic [1:0]  R_RESP    = 2'd2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic [31:0] mem [0:MEM_WORDS-1];

   logic unused_prot;
   assign unused_prot = ^{axi_arprot, axi_awprot};

   // ---------------- write path ----------------
   logic [0:0]                w_state;
   logic                      aw_got, w_got;
   logic [31:0]               aw_addr_q, w_data_q;
   logic [3:0]                w_strb_q;
   logic                      aw_hs, w_hs, wr_commit, wr_ok;
   logic [31:0]               wr_addr, wr_data, wr_off;
   logic [3:0]                wr_strb;
   logic [MEM_WORDS_LOG2-1:0] wr_idx;

   assign axi_awready = (w_state == W_IDLE) && !aw_got;
   assign axi_wready  = (w_state == W_IDLE) && !w_got;
   assign aw_hs       = axi_awvalid && axi_awready;
   assign w_hs        = axi_wvalid && axi_wready;

   // A payload completing this cycle is used directly so same-cycle AW/W commits at once.
   assign wr_addr   = aw_got ? aw_addr_q : axi_awaddr;
   assign wr_data   = w_got  ? w_data_q  : axi_wdata;
   assign wr_strb   = w_got  ? w_strb_q  : axi_wstrb;
   assign wr_commit = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
   assign wr_off    = wr_addr - BASE_ADDR;
   assign wr_ok     = (wr_off >> (MEM_WORDS_LOG2 + 2)) == 32'd0;
   assign wr_idx    = wr_off[MEM_WORDS_LOG2+1:2];

   always_ff @(posedge clk) begin
      if (aw_hs) aw_addr_q <= axi_awaddr;
      if (w_hs) begin
         w_data_q <= axi_wdata;
         w_strb_q <= axi_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state    <= W_IDLE;
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
         axi_bvalid <= 1'b0;
         axi_bresp  <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) aw_got <= 1'b1;
               if (w_hs)  w_got  <= 1'b1;
               if (wr_commit) begin
                  w_state    <= W_RESP;
                  axi_bvalid <= 1'b1;
                  axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            default: begin
               if (axi_bready) begin
                  w_state    <= W_IDLE;
                  aw_got     <= 1'b0;
                  w_got      <= 1'b0;
                  axi_bvalid <= 1'b0;
               end
            end
         endcase
      end
   end

   // RAM is not reset; a commit is suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst && wr_commit && wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   logic [1:0]                r_state;
   logic [31:0]               ar_addr_q, rd_off;
   logic                      rd_ok;
   logic [MEM_WORDS_LOG2-1:0] rd_idx;

   assign axi_arready = (r_state == R_IDLE);
   assign rd_off      = ar_addr_q - BASE_ADDR;
   assign rd_ok       = (rd_off >> (MEM_WORDS_LOG2 + 2)) == 32'd0;
   assign rd_idx      = rd_off[MEM_WORDS_LOG2+1:2];

   always_ff @(posedge clk) begin
      if (axi_arvalid && axi_arready) ar_addr_q <= axi_araddr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= R_IDLE;
         axi_rvalid <= 1'b0;
         axi_rdata  <= 32'h0;
         axi_rresp  <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (axi_arvalid) r_state <= R_READ;
            end
            R_READ: begin
               // Non-blocking read of mem gives old data on a same-edge write.
               axi_rdata  <= rd_ok ? mem[rd_idx] : 32'h0;
               axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
               axi_rvalid <= 1'b1;
               r_state    <= R_RESP;
            end
            R_RESP: begin
               if (axi_rready) begin
                  axi_rvalid <= 1'b0;
                  r_state    <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Randomized bench for axi_lite_ram_slave against a word-array reference model.
// A second instance with a high base address shares the stimulus to exercise offset wrap.
module tb_axi_lite_ram_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] araddr, awaddr, wdata;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic [3:0]  wstrb;
   logic [2:0]  arprot, awprot;

   logic        d0_arready, d0_rvalid, d0_awready, d0_wready, d0_bvalid;
   logic [31:0] d0_rdata;
   logic [1:0]  d0_rresp, d0_bresp;
   logic        d1_arready, d1_rvalid, d1_awready, d1_wready, d1_bvalid;
   logic [31:0] d1_rdata;
   logic [1:0]  d1_rresp, d1_bresp;

   axi_lite_ram_slave dut (
      .clk(clk), .rst(rst),
      .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(d0_arready), .axi_arprot(arprot),
      .axi_rdata(d0_rdata), .axi_rresp(d0_rresp), .axi_rvalid(d0_rvalid), .axi_rready(rready),
      .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(d0_awready), .axi_awprot(awprot),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(d0_wready),
      .axi_bresp(d0_bresp), .axi_bvalid(d0_bvalid), .axi_bready(bready)
   );

   axi_lite_ram_slave #(.MEM_WORDS_LOG2(4), .BASE_ADDR(32'h8000_0000)) dut_hi (
      .clk(clk), .rst(rst),
      .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(d1_arready), .axi_arprot(arprot),
      .axi_rdata(d1_rdata), .axi_rresp(d1_rresp), .axi_rvalid(d1_rvalid), .axi_rready(rready),
      .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(d1_awready), .axi_awprot(awprot),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(d1_wready),
      .axi_bresp(d1_bresp), .axi_bvalid(d1_bvalid), .axi_bready(bready)
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] model [0:31];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic logic in_map(input logic [31:0] a);
      return a < 32'h4000;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return in_map(a) ? model[a[6:2]] : 32'h0;
   endfunction

   // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly,
                            output logic [1:0] resp, output logic [1:0] resp1);
      int aw_start, w_start, cyc;
      bit awd, wdd, aw_hs, w_hs;
      aw_start = (lead > 0) ? lead : 0;
      w_start  = (lead < 0) ? -lead : 0;
      cyc = 0; awd = 0; wdd = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(awd && wdd) && cyc < 64) begin
         @(negedge clk);
         awvalid = !awd && (cyc >= aw_start);
         wvalid  = !wdd && (cyc >= w_start);
         aw_hs = awvalid && d0_awready;
         w_hs  = wvalid && d0_wready;
         @(posedge clk);
         awd = awd | aw_hs;
         wdd = wdd | w_hs;
         cyc++;
      end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("aw_w_accepted", 32'(awd && wdd), 32'd1);
      chk("b_latency", 32'(d0_bvalid), 32'd1);
      chk("readies_in_resp", 32'({d0_awready, d0_wready}), 32'd0);
      resp  = d0_bresp;
      resp1 = d1_bresp;
      for (int i = 0; i < bdly; i++) begin
         @(negedge clk);
         chk("b_hold", 32'({d0_bvalid, d0_bresp}), 32'({1'b1, resp}));
      end
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      chk("b_done", 32'({d0_bvalid, d0_awready, d0_wready}), 32'b011);
   endtask

   task automatic axi_read(input logic [31:0] a, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic [31:0] data1, output logic [1:0] resp1);
      int cyc;
      bit hs;
      cyc = 0; hs = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      while (!hs && cyc < 64) begin
         hs = d0_arready;
         @(posedge clk);
         cyc++;
         if (!hs) @(negedge clk);
      end
      @(negedge clk);
      arvalid = 1'b0;
      chk("ar_accepted", 32'(hs), 32'd1);
      chk("r_not_early", 32'({d0_rvalid, d0_arready}), 32'd0);
      @(negedge clk);
      chk("r_latency", 32'(d0_rvalid), 32'd1);
      data = d0_rdata; resp = d0_rresp; data1 = d1_rdata; resp1 = d1_rresp;
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         chk("r_hold_vld", 32'(d0_rvalid), 32'd1);
         chk("r_hold_dat", d0_rdata, data);
      end
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      chk("r_done", 32'({d0_rvalid, d0_arready}), 32'b01);
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lead, input int bdly);
      logic [1:0]  r, r1;
      logic [31:0] mask;
      axi_write(a, d, s, lead, bdly, r, r1);
      if (in_map(a)) begin
         chk("bresp_okay", 32'(r), 32'd0);
         mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
         model[a[6:2]] = (model[a[6:2]] & ~mask) | (d & mask);
      end else begin
         chk("bresp_slverr", 32'(r), 32'd2);
      end
   endtask

   task automatic do_rd(input logic [31:0] a, input int rdly);
      logic [31:0] d, d1;
      logic [1:0]  r, r1;
      axi_read(a, rdly, d, r, d1, r1);
      chk("rdata", d, exp_word(a));
      chk("rresp", 32'(r), in_map(a) ? 32'd0 : 32'd2);
   endtask

   task automatic pulse_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] a, d, d1, old;
      logic [1:0]  r, r1, br, br1;
      logic [31:0] oor [3] = '{32'h0000_4000, 32'hFFFF_FFFC, 32'h7FFF_FFFC};

      rst = 1'b1; arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
      araddr = 0; awaddr = 0; wdata = 0; wstrb = 0; arprot = 3'b000; awprot = 3'b000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_readies", 32'({d0_awready, d0_wready, d0_arready}), 32'b111);
      chk("rst_valids", 32'({d0_bvalid, d0_rvalid}), 32'd0);
      chk("rst_resps", 32'({d0_bresp, d0_rresp}), 32'd0);
      chk("rst_rdata", d0_rdata, 32'd0);

      // Preload word 4, then reset again: RAM contents survive reset.
      do_wr(32'h10, 32'hA5A5_5A5A, 4'hF, 0, 0);
      pulse_reset(2);
      do_rd(32'h10, 0);

      do_wr(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0);
      do_rd(32'h40, 0);
      do_wr(32'h40, 32'h1122_3344, 4'b0101, 3, 0);
      @(negedge clk);
      chk("single_b", 32'(d0_bvalid), 32'd0);
      do_rd(32'h40, 0);
      chk("strobe_merge", model[16], 32'hDE22_BE44);

      // Read and write outstanding together under backpressure; read samples on the commit edge.
      old = model[16];
      fork
         axi_read(32'h40, 10, d, r, d1, r1);
         begin
            @(negedge clk);
            axi_write(32'h40, 32'h0BAD_CAFE, 4'hF, 0, 10, br, br1);
         end
      join
      chk("same_edge_old", d, old);
      chk("same_edge_rresp", 32'(r), 32'd0);
      chk("same_edge_bresp", 32'(br), 32'd0);
      model[16] = 32'h0BAD_CAFE;
      do_rd(32'h40, 0);

      // Reset while write sits in W_RESP and read sits in R_READ.
      @(negedge clk);
      awaddr = 32'h44; wdata = 32'h5A5A_1234; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("mid_bvalid", 32'(d0_bvalid), 32'd1);
      araddr = 32'h40; arvalid = 1;
      @(negedge clk);
      arvalid = 0; rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid_rst_state", 32'({d0_bvalid, d0_rvalid, d0_awready, d0_wready, d0_arready}), 32'b00111);
      model[17] = 32'h5A5A_1234;
      do_rd(32'h44, 0);

      for (int w = 0; w < 32; w++) do_wr(32'(w) * 4, $urandom, 4'hF, 0, 0);

      do_wr(32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0);
      do_rd(32'h0, 0);
      do_rd(32'h4000, 0);

      // High-base instance: wrapped offset is out of range, own window works.
      axi_read(32'h7FFF_FFFC, 0, d, r, d1, r1);
      chk("wrap_rresp", 32'(r1), 32'd2);
      chk("wrap_rdata", d1, 32'd0);
      axi_write(32'h8000_0008, 32'hCAFE_F00D, 4'hF, -2, 0, br, br1);
      chk("hi_bresp", 32'(br1), 32'd0);
      chk("lo_bresp_hi_addr", 32'(br), 32'd2);
      do_rd(32'h8, 0);
      axi_read(32'h8000_0008, 0, d, r, d1, r1);
      chk("hi_rdata", d1, 32'hCAFE_F00D);
      chk("hi_rresp", 32'(r1), 32'd0);

      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 2)] + 32'($urandom_range(0, 3)) * 16;
         else a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_wr(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)));
         else
            do_rd(a, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
